seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 136 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed four-digit seven-segment scan back into hex nibbles,
// decimal points and blank/illegal-glyph flags, with a stability filter per digit.
module seg_scan_decoder #(
    parameter int unsigned STABLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_en,
    input  logic [3:0]  an,
    input  logic [7:0]  segment,
    output logic [15:0] hex,
    output logic [3:0]  points,
    output logic [3:0]  blank,
    output logic [3:0]  invalid,
    output logic        frame_valid,
    output logic        an_err
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    // Returns {legal, value} for an active-low {a..g} pattern.
    function automatic logic [4:0] glyph_decode(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'h01:   r = 5'h10;
            7'h4F:   r = 5'h11;
            7'h12:   r = 5'h12;
            7'h06:   r = 5'h13;
            7'h4C:   r = 5'h14;
            7'h24:   r = 5'h15;
            7'h20:   r = 5'h16;
            7'h0F:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h04:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h60:   r = 5'h1B;
            7'h31:   r = 5'h1C;
            7'h42:   r = 5'h1D;
            7'h30:   r = 5'h1E;
            7'h38:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [3:0] run_an_p0;
    logic [7:0] run_seg_p0;
    logic [3:0] run_cnt_p0;
    logic [3:0] mask_p0;

    logic       one_sel;
    logic       multi_sel;
    logic [1:0] idx;
    logic       match;
    logic [3:0] cnt_next;
    logic       commit;
    logic [4:0] dec;
    logic [3:0] mask_set;

    // Sample classification and run tracking
    always_comb begin
        one_sel = 1'b1;
        idx     = 2'd0;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_sel = 1'b0;
        endcase
        multi_sel = !one_sel && (an != 4'b1111);

        match = (an == run_an_p0) && (segment == run_seg_p0);
        if (match)
            cnt_next = (run_cnt_p0 == STABLE_C) ? STABLE_C : run_cnt_p0 + 4'd1;
        else
            cnt_next = 4'd1;

        // A saturated run that keeps matching must not commit again.
        commit   = one_sel && (cnt_next == STABLE_C) && !(match && run_cnt_p0 == STABLE_C);
        dec      = glyph_decode(segment[7:1]);
        mask_set = mask_p0 | ~an;
    end

    // Registered run state and decoded outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_an_p0   <= 4'd0;
            run_seg_p0  <= 8'd0;
            run_cnt_p0  <= 4'd0;
            mask_p0     <= 4'd0;
            hex         <= 16'd0;
            points      <= 4'd0;
            blank       <= 4'hF;
            invalid     <= 4'd0;
            frame_valid <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            an_err      <= 1'b0;
            if (sample_en) begin
                if (multi_sel) begin
                    an_err     <= 1'b1;
                    run_cnt_p0 <= 4'd0;
                    mask_p0    <= 4'd0;
                end else if (one_sel) begin
                    run_an_p0  <= an;
                    run_seg_p0 <= segment;
                    run_cnt_p0 <= cnt_next;
                    if (commit) begin
                        points[idx] <= ~segment[0];
                        if (dec[4]) begin
                            hex[{idx, 2'b00} +: 4] <= dec[3:0];
                            blank[idx]             <= 1'b0;
                            invalid[idx]           <= 1'b0;
                        end else if (segment[7:1] == 7'h7F) begin
                            hex[{idx, 2'b00} +: 4] <= 4'd0;
                            blank[idx]             <= 1'b1;
                            invalid[idx]           <= 1'b0;
                        end else begin
                            blank[idx]   <= 1'b0;
                            invalid[idx] <= 1'b1;
                        end
                        if (mask_set == 4'hF) begin
                            frame_valid <= 1'b1;
                            mask_p0     <= 4'd0;
                        end else begin
                            mask_p0 <= mask_set;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE=4: scan frames, errors,
// blank/illegal glyphs, reset mid-run, ignored samples and saturated runs.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [7:0]  segment = 8'hFF;
    logic [15:0] hex;
    logic [3:0]  points;
    logic [3:0]  blank;
    logic [3:0]  invalid;
    logic        frame_valid;
    logic        an_err;

    int tests = 0;
    int fails = 0;

    seg_scan_decoder #(.STABLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .an(an), .segment(segment),
        .hex(hex), .points(points), .blank(blank), .invalid(invalid),
        .frame_valid(frame_valid), .an_err(an_err)
    );

    always #5 clk = ~clk;

    task automatic smp(input logic [3:0] a, input logic [7:0] s);
        an = a;
        segment = s;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic digit(input logic [3:0] a, input logic [7:0] s);
        repeat (4) smp(a, s);
    endtask

    task automatic idle(input int n);
        sample_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sample_en = 1'b0;
        an = 4'hF;
        segment = 8'hFF;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (hex !== 16'h0000) begin fails++; $display("FAIL reset_hex got=%h exp=0000", hex); end
        tests++; if (points !== 4'h0) begin fails++; $display("FAIL reset_points got=%h exp=0", points); end
        tests++; if (blank !== 4'hF) begin fails++; $display("FAIL reset_blank got=%h exp=f", blank); end
        tests++; if (invalid !== 4'h0) begin fails++; $display("FAIL reset_invalid got=%h exp=0", invalid); end
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
        tests++; if (an_err !== 1'b0) begin fails++; $display("FAIL reset_an_err got=%b exp=0", an_err); end
    endtask

    task automatic test_frame();
        do_reset();
        repeat (3) smp(4'b1110, 8'h0D);
        tests++; if (hex !== 16'h0000) begin fails++; $display("FAIL frame_early_hex got=%h exp=0000", hex); end
        tests++; if (blank !== 4'hF) begin fails++; $display("FAIL frame_early_blank got=%h exp=f", blank); end
        smp(4'b1110, 8'h0D);
        tests++; if (hex !== 16'h0003) begin fails++; $display("FAIL frame_d0_hex got=%h exp=0003", hex); end
        tests++; if (blank !== 4'hE) begin fails++; $display("FAIL frame_d0_blank got=%h exp=e", blank); end
        digit(4'b1101, 8'h9F);
        digit(4'b1011, 8'h03);
        repeat (3) smp(4'b0111, 8'h71);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL frame_fv_15 got=%b exp=0", frame_valid); end
        smp(4'b0111, 8'h71);
        tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL frame_fv_16 got=%b exp=1", frame_valid); end
        tests++; if (hex !== 16'hF013) begin fails++; $display("FAIL frame_hex got=%h exp=f013", hex); end
        tests++; if (points !== 4'h0) begin fails++; $display("FAIL frame_points got=%h exp=0", points); end
        tests++; if (blank !== 4'h0) begin fails++; $display("FAIL frame_blank got=%h exp=0", blank); end
        tests++; if (invalid !== 4'h0) begin fails++; $display("FAIL frame_invalid got=%h exp=0", invalid); end
        idle(1);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL frame_fv_pulse got=%b exp=0", frame_valid); end
    endtask

    task automatic test_no_commit();
        do_reset();
        repeat (3) smp(4'b1110, 8'h24);
        smp(4'b1110, 8'h25);
        tests++; if (hex !== 16'h0000) begin fails++; $display("FAIL nocommit_hex got=%h exp=0000", hex); end
        tests++; if (blank !== 4'hF) begin fails++; $display("FAIL nocommit_blank got=%h exp=f", blank); end
    endtask

    task automatic test_an_err();
        do_reset();
        digit(4'b1110, 8'h0D);
        digit(4'b1101, 8'h9F);
        smp(4'b1100, 8'h0D);
        tests++; if (an_err !== 1'b1) begin fails++; $display("FAIL anerr_pulse got=%b exp=1", an_err); end
        idle(1);
        tests++; if (an_err !== 1'b0) begin fails++; $display("FAIL anerr_clear got=%b exp=0", an_err); end
        digit(4'b1011, 8'h03);
        digit(4'b0111, 8'h71);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL anerr_no_fv got=%b exp=0", frame_valid); end
        tests++; if (hex !== 16'hF013) begin fails++; $display("FAIL anerr_hex got=%h exp=f013", hex); end
        digit(4'b1110, 8'h0D);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL anerr_fv_d0 got=%b exp=0", frame_valid); end
        digit(4'b1101, 8'h9F);
        tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL anerr_fv_full got=%b exp=1", frame_valid); end
    endtask

    task automatic test_blank_invalid();
        do_reset();
        digit(4'b1011, 8'h00);
        tests++; if (hex[11:8] !== 4'h8) begin fails++; $display("FAIL bi_eight got=%h exp=8", hex[11:8]); end
        tests++; if (points[2] !== 1'b1) begin fails++; $display("FAIL bi_eight_point got=%b exp=1", points[2]); end
        digit(4'b1011, 8'hFE);
        tests++; if (blank[2] !== 1'b1) begin fails++; $display("FAIL bi_blank got=%b exp=1", blank[2]); end
        tests++; if (points[2] !== 1'b1) begin fails++; $display("FAIL bi_blank_point got=%b exp=1", points[2]); end
        tests++; if (hex[11:8] !== 4'h0) begin fails++; $display("FAIL bi_blank_hex got=%h exp=0", hex[11:8]); end
        tests++; if (invalid[2] !== 1'b0) begin fails++; $display("FAIL bi_blank_inv got=%b exp=0", invalid[2]); end
        digit(4'b1011, 8'h49);
        tests++; if (hex[11:8] !== 4'h5) begin fails++; $display("FAIL bi_five got=%h exp=5", hex[11:8]); end
        tests++; if (points[2] !== 1'b0) begin fails++; $display("FAIL bi_five_point got=%b exp=0", points[2]); end
        tests++; if (blank[2] !== 1'b0) begin fails++; $display("FAIL bi_five_blank got=%b exp=0", blank[2]); end
        digit(4'b1011, 8'h55);
        tests++; if (invalid[2] !== 1'b1) begin fails++; $display("FAIL bi_invalid got=%b exp=1", invalid[2]); end
        tests++; if (hex[11:8] !== 4'h5) begin fails++; $display("FAIL bi_invalid_hex got=%h exp=5", hex[11:8]); end
        tests++; if (blank[2] !== 1'b0) begin fails++; $display("FAIL bi_invalid_blank got=%b exp=0", blank[2]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        digit(4'b1101, 8'h9F);
        tests++; if (hex !== 16'h0010) begin fails++; $display("FAIL rmid_pre_hex got=%h exp=0010", hex); end
        repeat (2) smp(4'b1110, 8'h0D);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (hex !== 16'h0000) begin fails++; $display("FAIL rmid_async_hex got=%h exp=0000", hex); end
        tests++; if (blank !== 4'hF) begin fails++; $display("FAIL rmid_async_blank got=%h exp=f", blank); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) smp(4'b1110, 8'h0D);
        tests++; if (hex !== 16'h0000) begin fails++; $display("FAIL rmid_hex got=%h exp=0000", hex); end
        tests++; if (blank !== 4'hF) begin fails++; $display("FAIL rmid_blank got=%h exp=f", blank); end
        tests++; if (points !== 4'h0) begin fails++; $display("FAIL rmid_points got=%h exp=0", points); end
        tests++; if (invalid !== 4'h0) begin fails++; $display("FAIL rmid_invalid got=%h exp=0", invalid); end
        repeat (2) smp(4'b1110, 8'h0D);
        tests++; if (hex !== 16'h0003) begin fails++; $display("FAIL rmid_full_hex got=%h exp=0003", hex); end
        tests++; if (blank !== 4'hE) begin fails++; $display("FAIL rmid_full_blank got=%h exp=e", blank); end
    endtask

    task automatic test_ignore();
        do_reset();
        repeat (2) smp(4'b1110, 8'h0D);
        smp(4'b1111, 8'h0D);
        tests++; if (an_err !== 1'b0) begin fails++; $display("FAIL ign_an_err got=%b exp=0", an_err); end
        an = 4'b1110;
        segment = 8'h55;
        idle(2);
        smp(4'b1110, 8'h0D);
        tests++; if (hex !== 16'h0000) begin fails++; $display("FAIL ign_early_hex got=%h exp=0000", hex); end
        smp(4'b1110, 8'h0D);
        tests++; if (hex !== 16'h0003) begin fails++; $display("FAIL ign_hex got=%h exp=0003", hex); end
        tests++; if (invalid !== 4'h0) begin fails++; $display("FAIL ign_invalid got=%h exp=0", invalid); end
    endtask

    task automatic test_saturate();
        int fvcnt;
        do_reset();
        digit(4'b1110, 8'h0D);
        digit(4'b1101, 8'h9F);
        digit(4'b1011, 8'h03);
        fvcnt = 0;
        repeat (20) begin
            smp(4'b0111, 8'h00);
            if (frame_valid === 1'b1) fvcnt++;
        end
        tests++; if (fvcnt !== 1) begin fails++; $display("FAIL sat_fv_count got=%0d exp=1", fvcnt); end
        tests++; if (hex[15:12] !== 4'h8) begin fails++; $display("FAIL sat_hex got=%h exp=8", hex[15:12]); end
        tests++; if (points[3] !== 1'b1) begin fails++; $display("FAIL sat_point got=%b exp=1", points[3]); end
        digit(4'b1110, 8'h0D);
        digit(4'b1101, 8'h9F);
        digit(4'b1011, 8'h03);
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL sat_no_frame got=%b exp=0", frame_valid); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_no_commit();
        test_an_err();
        test_blank_invalid();
        test_reset_mid();
        test_ignore();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
